// File: rtl/bitsim_column_sequencer.sv
// Column sequencer for one bit-serial MAC unit.
// Takes one job descriptor and then a stream of weight-column descriptors.
// Zero columns may be left out of the stream.
// Each accepted column is issued to the MAC on the following cycle.
// After the last column, one drain cycle flushes the MAC's 2-stage pipeline.
// The result is then held under a valid/ready handshake.
// Any cycle without an issued column carries bubble values, so the MAC's
// contribution in that cycle is exactly zero.
module bitsim_column_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 16,
    parameter int SEL_WIDTH  = $clog2(VEC_LENGTH) - 1,
    parameter int COL_W      = $clog2(DATA_WIDTH)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                job_valid,
    output logic                                job_ready,
    input  logic                                job_use_prev,
    input  logic                                job_pool,
    input  logic                                col_valid,
    output logic                                col_ready,
    input  logic                                col_last,
    input  logic [COL_W-1:0]                    col_idx,
    input  logic [VEC_LENGTH/2*SEL_WIDTH-1:0]   col_act_sel,
    input  logic [VEC_LENGTH/2-1:0]             col_act_val,
    input  logic [2:0]                          col_mul_const,
    input  logic                                col_shift_mul,
    input  logic [VEC_LENGTH/8-1:0]             col_skip_zero,
    output logic                                mac_en,
    output logic                                mac_load_accum,
    output logic                                mac_is_msb,
    output logic                                mac_shift_mul,
    output logic                                mac_is_pooling,
    output logic [2:0]                          mac_column_idx,
    output logic [VEC_LENGTH/2*SEL_WIDTH-1:0]   mac_act_sel,
    output logic [VEC_LENGTH/2-1:0]             mac_act_val,
    output logic [2:0]                          mac_mul_const,
    output logic [VEC_LENGTH/8-1:0]             mac_skip_zero,
    output logic                                clear_prev,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic                                col_err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic             use_prev_q;
    logic             pool_q;
    logic             issued_q;     // the job's first column has been issued
    logic             loaded_q;     // load_accum has already fired for this job
    logic             have_prev_q;  // prev_idx_q holds a column of this job
    logic [COL_W-1:0] prev_idx_q;

    logic col_acc;
    logic en_next;
    logic load_next;

    assign job_ready = (state == IDLE);
    assign col_ready = (state == RUN);
    assign col_acc   = col_valid && col_ready;

    // load_accum goes on the first enabled cycle after the first issue.
    // Bubbles do not count, because the MAC is frozen while en is low.
    assign en_next   = col_acc || (state == DRAIN);
    assign load_next = en_next && issued_q && !loaded_q;

    // Job FSM; every MAC-facing output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            use_prev_q     <= 1'b0;
            pool_q         <= 1'b0;
            issued_q       <= 1'b0;
            loaded_q       <= 1'b0;
            have_prev_q    <= 1'b0;
            prev_idx_q     <= '0;
            mac_en         <= 1'b0;
            mac_load_accum <= 1'b0;
            mac_is_msb     <= 1'b0;
            mac_shift_mul  <= 1'b0;
            mac_is_pooling <= 1'b0;
            mac_column_idx <= '0;
            mac_act_sel    <= '0;
            mac_act_val    <= '0;
            mac_mul_const  <= '0;
            mac_skip_zero  <= '1;
            clear_prev     <= 1'b0;
            out_valid      <= 1'b0;
            col_err        <= 1'b0;
        end else begin
            // Bubble defaults. column_idx and act_sel are left untouched,
            // since a bubble with act_val=0 ignores them.
            mac_en         <= 1'b0;
            mac_load_accum <= 1'b0;
            mac_is_msb     <= 1'b0;
            mac_shift_mul  <= 1'b0;
            mac_act_val    <= '0;
            mac_mul_const  <= '0;
            mac_skip_zero  <= '1;

            if (load_next) begin
                mac_load_accum <= 1'b1;
                loaded_q       <= 1'b1;
            end
            // clear_prev covers the window from first issue through the load cycle
            if (mac_load_accum)
                clear_prev <= 1'b0;

            case (state)
                IDLE: begin
                    if (job_valid) begin
                        use_prev_q  <= job_use_prev;
                        pool_q      <= job_pool;
                        col_err     <= 1'b0;
                        issued_q    <= 1'b0;
                        loaded_q    <= 1'b0;
                        have_prev_q <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (col_acc) begin
                        mac_en         <= 1'b1;
                        mac_column_idx <= 3'(col_idx);
                        mac_is_msb     <= (col_idx == COL_W'(DATA_WIDTH - 1));
                        mac_act_sel    <= col_act_sel;
                        mac_act_val    <= col_act_val;
                        mac_mul_const  <= col_mul_const;
                        mac_shift_mul  <= col_shift_mul;
                        mac_skip_zero  <= col_skip_zero;
                        if (!issued_q) begin
                            clear_prev <= ~use_prev_q;
                            issued_q   <= 1'b1;
                        end
                        // A column that is not above its predecessor is still processed.
                        if (have_prev_q && (col_idx <= prev_idx_q))
                            col_err <= 1'b1;
                        prev_idx_q  <= col_idx;
                        have_prev_q <= 1'b1;
                        if (col_last)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mac_en <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid      <= 1'b0;
                        mac_is_pooling <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        out_valid      <= 1'b1;
                        mac_is_pooling <= pool_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitsim_column_sequencer.sv
// Self-checking bench for bitsim_column_sequencer.
// Each job is described as a list of columns with idle gaps between them.
// From that list the bench computes the edge on which every event should occur:
// column accepts, issue cycles, load, drain, the result window and the handshake.
// It then checks the DUT outputs cycle by cycle against those expectations.
module tb_bitsim_column_sequencer;

    localparam int DW = 8;
    localparam int VL = 16;
    localparam int SW = $clog2(VL) - 1;
    localparam int CW = $clog2(DW);
    localparam int NM = VL / 2;
    localparam int NG = VL / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              job_valid, job_ready, job_use_prev, job_pool;
    logic              col_valid, col_ready, col_last;
    logic [CW-1:0]     col_idx;
    logic [NM*SW-1:0]  col_act_sel;
    logic [NM-1:0]     col_act_val;
    logic [2:0]        col_mul_const;
    logic              col_shift_mul;
    logic [NG-1:0]     col_skip_zero;
    logic              mac_en, mac_load_accum, mac_is_msb, mac_shift_mul, mac_is_pooling;
    logic [2:0]        mac_column_idx;
    logic [NM*SW-1:0]  mac_act_sel;
    logic [NM-1:0]     mac_act_val;
    logic [2:0]        mac_mul_const;
    logic [NG-1:0]     mac_skip_zero;
    logic              clear_prev, out_valid, out_ready, col_err;

    bitsim_column_sequencer #(.DATA_WIDTH(DW), .VEC_LENGTH(VL)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_use_prev(job_use_prev), .job_pool(job_pool),
        .col_valid(col_valid), .col_ready(col_ready), .col_last(col_last),
        .col_idx(col_idx), .col_act_sel(col_act_sel), .col_act_val(col_act_val),
        .col_mul_const(col_mul_const), .col_shift_mul(col_shift_mul),
        .col_skip_zero(col_skip_zero),
        .mac_en(mac_en), .mac_load_accum(mac_load_accum), .mac_is_msb(mac_is_msb),
        .mac_shift_mul(mac_shift_mul), .mac_is_pooling(mac_is_pooling),
        .mac_column_idx(mac_column_idx), .mac_act_sel(mac_act_sel),
        .mac_act_val(mac_act_val), .mac_mul_const(mac_mul_const),
        .mac_skip_zero(mac_skip_zero), .clear_prev(clear_prev),
        .out_valid(out_valid), .out_ready(out_ready), .col_err(col_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Column list for the job about to be run.
    logic [CW-1:0]    c_idx [DW];
    logic [NM*SW-1:0] c_sel [DW];
    logic [NM-1:0]    c_val [DW];
    logic [2:0]       c_mul [DW];
    logic             c_sh  [DW];
    logic [NG-1:0]    c_skip[DW];
    int               c_gap [DW];

    task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @c%0d: observed 0x%0h expected 0x%0h", tag, c, obs, exp);
        end
    endtask

    task automatic rand_fields(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            c_sel[i]  = (NM*SW)'($urandom);
            c_val[i]  = NM'($urandom);
            c_mul[i]  = 3'($urandom);
            c_sh[i]   = 1'($urandom);
            c_skip[i] = NG'($urandom);
            c_gap[i]  = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
        end
    endtask

    task automatic chk_reset_state(input int c);
        chk("rst_en", c, 32'(mac_en), 0);
        chk("rst_load", c, 32'(mac_load_accum), 0);
        chk("rst_msb", c, 32'(mac_is_msb), 0);
        chk("rst_shift", c, 32'(mac_shift_mul), 0);
        chk("rst_pool", c, 32'(mac_is_pooling), 0);
        chk("rst_colidx", c, 32'(mac_column_idx), 0);
        chk("rst_sel", c, 32'(mac_act_sel), 0);
        chk("rst_val", c, 32'(mac_act_val), 0);
        chk("rst_mul", c, 32'(mac_mul_const), 0);
        chk("rst_skip", c, 32'(mac_skip_zero), 32'((1 << NG) - 1));
        chk("rst_clear", c, 32'(clear_prev), 0);
        chk("rst_ovalid", c, 32'(out_valid), 0);
        chk("rst_colerr", c, 32'(col_err), 0);
        chk("rst_jready", c, 32'(job_ready), 1);
        chk("rst_cready", c, 32'(col_ready), 0);
    endtask

    task automatic drive_junk_col();
        col_valid     = 1'b0;
        col_last      = 1'b0;
        col_idx       = CW'($urandom);
        col_act_sel   = (NM*SW)'($urandom);
        col_act_val   = NM'($urandom);
        col_mul_const = 3'($urandom);
        col_shift_mul = 1'($urandom);
        col_skip_zero = NG'($urandom);
    endtask

    // Runs one job of n columns. Edge 0 is the job accept.
    // abort_k > 0 asserts reset right after the abort_k-th column is issued.
    task automatic run_job(input int n, input bit up, input bit pl, input int rdelay, input int abort_k);
        int acc[DW];
        int d, h, ld, issue, w;
        bit err, ov;
        acc[0] = 1 + c_gap[0];
        for (int i = 1; i < n; i++) acc[i] = acc[i-1] + 1 + c_gap[i];
        d  = acc[n-1] + 1;                 // drain edge
        h  = d + rdelay + 2;               // handshake edge
        ld = (n > 1) ? acc[1] : d;         // load_accum edge

        w = 0;
        while (job_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("job_ready_pre", w, 32'(job_ready), 1);

        job_valid    = 1'b1;
        job_use_prev = up;
        job_pool     = pl;
        out_ready    = 1'b0;
        drive_junk_col();

        for (int c = 0; c <= h; c++) begin
            @(posedge clk);
            @(negedge clk);
            job_valid    = 1'b0;
            job_use_prev = 1'($urandom);
            job_pool     = 1'($urandom);

            issue = -1;
            for (int i = 0; i < n; i++) if (acc[i] == c) issue = i;
            err = 1'b0;
            for (int j = 1; j < n; j++)
                if (acc[j] <= c && c_idx[j] <= c_idx[j-1]) err = 1'b1;
            ov = (c >= d + 1) && (c < h);

            chk("en", c, 32'(mac_en), 32'(issue >= 0 || c == d));
            chk("load", c, 32'(mac_load_accum), 32'(c == ld));
            chk("clear_prev", c, 32'(clear_prev), 32'(!up && c >= acc[0] && c <= ld));
            chk("is_msb", c, 32'(mac_is_msb), 32'(issue >= 0 && c_idx[issue] == CW'(DW - 1)));
            if (issue >= 0) begin
                chk("col_idx", c, 32'(mac_column_idx), 32'(c_idx[issue]));
                chk("act_sel", c, 32'(mac_act_sel), 32'(c_sel[issue]));
                chk("act_val", c, 32'(mac_act_val), 32'(c_val[issue]));
                chk("mul", c, 32'(mac_mul_const), 32'(c_mul[issue]));
                chk("shift", c, 32'(mac_shift_mul), 32'(c_sh[issue]));
                chk("skip", c, 32'(mac_skip_zero), 32'(c_skip[issue]));
            end else begin
                chk("bub_val", c, 32'(mac_act_val), 0);
                chk("bub_mul", c, 32'(mac_mul_const), 0);
                chk("bub_shift", c, 32'(mac_shift_mul), 0);
                chk("bub_skip", c, 32'(mac_skip_zero), 32'((1 << NG) - 1));
            end
            chk("out_valid", c, 32'(out_valid), 32'(ov));
            chk("pooling", c, 32'(mac_is_pooling), 32'(ov && pl));
            chk("col_err", c, 32'(col_err), 32'(err));
            chk("job_ready", c, 32'(job_ready), 32'(c >= h));
            chk("col_ready", c, 32'(col_ready), 32'(c < acc[n-1]));

            if (abort_k > 0 && issue == abort_k - 1) begin
                reset = 1'b1;
                drive_junk_col();
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                chk_reset_state(c + 1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("abort_ovalid", c + 2 + k, 32'(out_valid), 0);
                    chk("abort_en", c + 2 + k, 32'(mac_en), 0);
                    chk("abort_jready", c + 2 + k, 32'(job_ready), 1);
                end
                return;
            end

            drive_junk_col();
            for (int i = 0; i < n; i++) begin
                if (acc[i] == c + 1) begin
                    col_valid     = 1'b1;
                    col_last      = (i == n - 1);
                    col_idx       = c_idx[i];
                    col_act_sel   = c_sel[i];
                    col_act_val   = c_val[i];
                    col_mul_const = c_mul[i];
                    col_shift_mul = c_sh[i];
                    col_skip_zero = c_skip[i];
                end
            end
            out_ready = (c >= d + 1 + rdelay);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int n, m;
        reset        = 1'b1;
        job_valid    = 1'b0;
        job_use_prev = 1'b0;
        job_pool     = 1'b0;
        out_ready    = 1'b0;
        drive_junk_col();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state(0);
        reset = 1'b0;
        @(negedge clk);

        // Dense job: columns 0..7 back to back, with use_prev=0.
        rand_fields(8, 0);
        for (int i = 0; i < 8; i++) c_idx[i] = CW'(i);
        run_job(8, 1'b0, 1'b0, 0, 0);

        // Single column with idx 3 and use_prev=1; load_accum falls in the drain cycle.
        rand_fields(1, 0);
        c_idx[0] = 3'd3;
        run_job(1, 1'b1, 1'b0, 0, 0);

        // Sparse job {1,4,7} with 2-cycle gaps between columns.
        rand_fields(3, 0);
        c_idx[0] = 3'd1; c_idx[1] = 3'd4; c_idx[2] = 3'd7;
        for (int i = 0; i < 3; i++) c_gap[i] = 2;
        run_job(3, 1'b0, 1'b0, 0, 0);

        // Out-of-order columns 5, 2, 6: col_err is sticky.
        rand_fields(3, 0);
        c_idx[0] = 3'd5; c_idx[1] = 3'd2; c_idx[2] = 3'd6;
        run_job(3, 1'b1, 1'b0, 1, 0);

        // Pooling job whose result is held for 5 cycles while out_ready stays low.
        rand_fields(4, 1);
        c_idx[0] = 3'd0; c_idx[1] = 3'd2; c_idx[2] = 3'd3; c_idx[3] = 3'd6;
        run_job(4, 1'b0, 1'b1, 5, 0);

        // Reset after 3 columns of a 6-column job, then a normal job.
        rand_fields(6, 1);
        for (int i = 0; i < 6; i++) c_idx[i] = CW'(i + 1);
        run_job(6, 1'b0, 1'b0, 0, 3);
        rand_fields(5, 1);
        for (int i = 0; i < 5; i++) c_idx[i] = CW'(i * 2 - (i / 4) * 1);
        run_job(5, 1'b0, 1'b1, 2, 0);

        // Randomized jobs: column order is mostly ascending, sometimes arbitrary.
        for (int r = 0; r < 24; r++) begin
            if ($urandom_range(0, 3) != 0) begin
                m = int'($urandom_range(1, 255));
                n = 0;
                for (int b = 0; b < DW; b++)
                    if (m[b]) begin c_idx[n] = CW'(b); n++; end
            end else begin
                n = int'($urandom_range(1, DW));
                for (int i = 0; i < n; i++) c_idx[i] = CW'($urandom);
            end
            rand_fields(n, 3);
            run_job(n, 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
